// File: rtl/fifo_rd_stream.sv
// Read-side stream controller for the control FIFO: drains tile_words words into a valid/ready stream.
// Optional build macro RD_BYTE_SWAP_EN byte-reverses each FIFO word on capture.
module fifo_rd_stream #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  tile_words,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len, iss, acc, acc_nxt;
  logic [1:0]        occ, occ_nxt;
  logic              infl;
  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr, rd_ptr;
  logic [DATA_W-1:0] in_word;
  logic              pop, wr, rd;
  logic [2:0]        room;

`ifdef RD_BYTE_SWAP_EN
  for (genvar i = 0; i < DATA_W/8; i++) begin : g_swap
    assign in_word[8*i +: 8] = fifo_rd_data[DATA_W-8-8*i +: 8];
  end
`else
  assign in_word = fifo_rd_data;
`endif

  // The word returning from the FIFO is visible on the stream in its arrival
  // cycle; it is only stored if it is not consumed right away.
  assign m_valid = (occ != 2'd0) || infl;
  assign m_data  = (occ == 2'd0 && infl) ? in_word : mem[rd_ptr];
  assign m_last  = m_valid && (acc == len - CNT_W'(1));

  assign pop     = m_valid && m_ready;
  assign wr      = infl && !(pop && occ == 2'd0);
  assign rd      = pop && (occ != 2'd0);
  assign occ_nxt = occ + {1'b0, wr} - {1'b0, rd};
  assign acc_nxt = acc + {{(CNT_W-1){1'b0}}, pop};
  assign room    = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (tile_words == '0) ? DONE : RUN;
      RUN:   if (fifo_rd_en && (iss + CNT_W'(1)) == len) state_nxt = DRAIN;
      DRAIN: if (acc_nxt == len && occ_nxt == 2'd0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state == RUN) && !fifo_empty && (iss < len) && (room < 3'd2);
    busy       = (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len    <= '0;
      iss    <= '0;
      acc    <= '0;
      occ    <= '0;
      infl   <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (state == IDLE && start) begin
        len <= tile_words;
        iss <= '0;
        acc <= '0;
      end else begin
        if (fifo_rd_en) iss <= iss + CNT_W'(1);
        acc <= acc_nxt;
      end
      infl <= fifo_rd_en;
      occ  <= occ_nxt;
      if (wr) begin
        mem[wr_ptr] <= in_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO source model, transaction-level scoreboard, directed tiles.
module tb_fifo_rd_stream;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  tile_words = '0;
  logic [255:0] fifo_rd_data = '0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [255:0] m_data;
  logic         m_last;
  logic         busy;
  logic         done;
  logic         hold_empty = 1'b0;

  int n_chk = 0, n_pass = 0;

  logic [255:0] src_mem [0:63];
  int src_wr = 0;
  int src_rd = 0;

  fifo_rd_stream #(.DATA_W(256), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_words(tile_words),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // FIFO with one-cycle read latency; flushed by reset
  assign fifo_empty = hold_empty || (src_rd == src_wr);
  always @(posedge clk or posedge rst) begin
    if (rst) src_rd <= src_wr;
    else if (fifo_rd_en) begin
      fifo_rd_data <= src_mem[src_rd];
      src_rd       <= src_rd + 1;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [255:0] pat(input int n);
    logic [255:0] w;
    for (int b = 0; b < 32; b++) w[8*b +: 8] = 8'(n*37 + b*11 + 5);
    return w;
  endfunction

  function automatic logic [255:0] xform(input logic [255:0] w);
`ifdef RD_BYTE_SWAP_EN
    logic [255:0] r;
    for (int b = 0; b < 32; b++) r[8*b +: 8] = w[8*(31-b) +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  // Scoreboard: words leave in FIFO order, last flag on word len, done the cycle after it.
  int mlen = 0, xfer = 0, issued = 0, exp_rd = 0;
  bit active = 0, mbusy = 0, exp_done = 0, stall_prev = 0, popped;
  logic [255:0] stall_data;

  always @(negedge clk) begin
    if (rst) begin
      active = 0; mbusy = 0; exp_done = 0; stall_prev = 0;
      xfer = 0; issued = 0; exp_rd = src_wr;
    end else begin
      chk("done", done, exp_done);
      chk("busy", busy, mbusy);
      chk("rd_while_empty", fifo_rd_en && fifo_empty, 1'b0);
      chk("valid_outside_tile", m_valid && !mbusy, 1'b0);
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1'b1);
        chk("stall_data", m_data, stall_data);
      end
      chk("last", m_last, m_valid && (xfer == mlen - 1));
      popped = m_valid && m_ready;
      if (fifo_rd_en) issued++;
      if (popped) begin
        chk("data", m_data, xform(src_mem[exp_rd]));
        exp_rd++;
        xfer++;
      end
      if (mbusy) begin
        chk("outstanding", (issued - xfer) <= 2, 1'b1);
        chk("over_read", issued <= mlen, 1'b1);
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      if (exp_done) begin
        exp_done = 0; active = 0;
      end else if (!active && start) begin
        active = 1; mlen = tile_words; xfer = 0; issued = 0;
        if (mlen == 0) exp_done = 1; else mbusy = 1;
      end else if (mbusy && popped && xfer == mlen) begin
        mbusy = 0; exp_done = 1;
      end
    end
  end

  int seed = 0;
  task automatic push(input logic [255:0] w);
    src_mem[src_wr] = w;
    src_wr++;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin push(pat(seed)); seed++; end
  endtask

  // One tile: ready low in cycles rl0..rl1, FIFO forced empty in e0..e1 (cycle 0 = start).
  task automatic run(input int len, input int rl0, input int rl1, input int e0, input int e1,
                     input bit busy_start, output logic [15:0] rdm, output logic [15:0] vm,
                     output logic [15:0] lm, output logic [15:0] dm, output logic [15:0] bm,
                     output logic [255:0] fd);
    bit got = 0, have_fd = 0;
    rdm = '0; vm = '0; lm = '0; dm = '0; bm = '0; fd = '0;
    @(posedge clk); #1;
    start = 1'b1; tile_words = 16'(len);
    for (int c = 1; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      start      = busy_start && (c == 2);
      tile_words = 16'(c + 40);
      m_ready    = !(c >= rl0 && c <= rl1);
      hold_empty = (c >= e0 && c <= e1);
      @(negedge clk);
      if (c < 16) begin
        rdm[c] = fifo_rd_en; vm[c] = m_valid; lm[c] = m_last; dm[c] = done; bm[c] = busy;
      end
      if (m_valid && m_ready && !have_fd) begin fd = m_data; have_fd = 1; end
      if (done) got = 1;
    end
    chk("tile_timeout", got, 1'b1);
    @(posedge clk); #1;
    start = 1'b0; m_ready = 1'b1; hold_empty = 1'b0;
  endtask

  logic [15:0] rdm, vm, lm, dm, bm;
  logic [255:0] fd, kw;
  int seen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 256'd0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    push_n(4);
    run(4, 0, -1, 0, -1, 0, rdm, vm, lm, dm, bm, fd);
    chk("t4_rd_en_cycles", rdm, 16'h001E);
    chk("t4_valid_cycles", vm, 16'h003C);
    chk("t4_last_cycle", lm, 16'h0020);
    chk("t4_done_cycle", dm, 16'h0040);
    chk("t4_busy_cycles", bm, 16'h003E);

    push_n(8);
    run(8, 3, 6, 0, -1, 1, rdm, vm, lm, dm, bm, fd);
    chk("t8_rd_stall", rdm[6:3], 4'b0001);

    push_n(6);
    run(6, 0, -1, 3, 5, 0, rdm, vm, lm, dm, bm, fd);
    chk("t6_no_rd_empty", rdm[5:3], 3'b000);
    chk("t6_one_last", $countones(lm), 1);

    run(0, 0, -1, 0, -1, 0, rdm, vm, lm, dm, bm, fd);
    chk("t0_done_cycle", dm, 16'h0002);
    chk("t0_no_rd", rdm, 16'h0000);
    chk("t0_no_valid", vm, 16'h0000);

    push_n(10);
    @(posedge clk); #1;
    start = 1'b1; tile_words = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) seen++;
    end
    chk("rst_mid_seen3", seen, 3);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst_rd_en", fifo_rd_en, 1'b0);
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_data", m_data, 256'd0);
    chk("mid_rst_last", m_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_n(2);
    run(2, 0, -1, 0, -1, 0, rdm, vm, lm, dm, bm, fd);
    chk("t2_after_rst_last", lm, 16'h0008);

    for (int k = 0; k < 32; k++) kw[8*k +: 8] = 8'(k);
    push(kw);
    run(1, 0, -1, 0, -1, 0, rdm, vm, lm, dm, bm, fd);
`ifdef RD_BYTE_SWAP_EN
    chk("swap_byte0", fd[7:0], 8'd31);
    chk("swap_byte31", fd[255:248], 8'd0);
`else
    chk("byte0", fd[7:0], 8'd0);
    chk("byte31", fd[255:248], 8'd31);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
